// File: rtl/rv32i_types.sv
// Shared RV32I core types: width constants, compare-op encodings and the
// branch unit's opcode and result packet.
package rv32i_types;

   localparam int XLEN          = 32;
   localparam int ROB_IDX_W_DEF = 5;
   localparam int PHYS_W_DEF    = 6;

   // funct3 encodings of the conditional branches
   localparam logic [2:0] CMP_EQ  = 3'b000;
   localparam logic [2:0] CMP_NE  = 3'b001;
   localparam logic [2:0] CMP_LT  = 3'b100;
   localparam logic [2:0] CMP_GE  = 3'b101;
   localparam logic [2:0] CMP_LTU = 3'b110;
   localparam logic [2:0] CMP_GEU = 3'b111;

   typedef enum logic [1:0] {
      BR_BR   = 2'd0,
      BR_JAL  = 2'd1,
      BR_JALR = 2'd2
   } br_op_t;

   typedef struct packed {
      logic [ROB_IDX_W_DEF-1:0] rob_idx;
      logic [PHYS_W_DEF-1:0]    pd;
      logic                     rd_we;
      logic [XLEN-1:0]          rd_v;
      logic                     taken;
      logic [XLEN-1:0]          next_pc;
      logic                     mispredict;
   } br_res_t;

endpackage

// File: rtl/br_fu_cmp.sv
// Branch comparator: evaluates a funct3 condition on two operands.
// Reserved encodings (010/011) and an invalid request both yield not-taken.
module cmp
   import rv32i_types::*;
(
   input  logic            valid,
   input  logic [2:0]      cmpop,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            br_en
);

   logic res;

   always_comb begin
      res = 1'b0;
      case (cmpop)
         CMP_EQ:  res = (a == b);
         CMP_NE:  res = (a != b);
         CMP_LT:  res = ($signed(a) <  $signed(b));
         CMP_GE:  res = ($signed(a) >= $signed(b));
         CMP_LTU: res = (a <  b);
         CMP_GEU: res = (a >= b);
         default: res = 1'b0;
      endcase
      br_en = valid && res;
   end

endmodule

// File: rtl/br_fu.sv
// Branch functional unit: resolves direction/target/link for one issued
// branch or jump per cycle and queues results in a 2-entry FIFO.
module br_fu
   import rv32i_types::*;
#(
   parameter int ROB_IDX_W = ROB_IDX_W_DEF,
   parameter int PHYS_W    = PHYS_W_DEF
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_op,
   input  logic [2:0]           in_cmpop,
   input  logic [31:0]          in_pc,
   input  logic [31:0]          in_rs1_v,
   input  logic [31:0]          in_rs2_v,
   input  logic [31:0]          in_imm,
   input  logic                 in_pred_taken,
   input  logic [31:0]          in_pred_target,
   input  logic [ROB_IDX_W-1:0] in_rob_idx,
   input  logic [PHYS_W-1:0]    in_pd,
   input  logic                 in_rd_we,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ROB_IDX_W-1:0] out_rob_idx,
   output logic [PHYS_W-1:0]    out_pd,
   output logic                 out_rd_we,
   output logic [31:0]          out_rd_v,
   output logic                 out_taken,
   output logic [31:0]          out_next_pc,
   output logic                 out_mispredict
);

   logic        cmp_taken;
   logic        is_jal;
   logic        is_jalr;
   logic        taken;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   br_res_t     res;

   cmp u_cmp (
      .valid (in_valid),
      .cmpop (in_cmpop),
      .a     (in_rs1_v),
      .b     (in_rs2_v),
      .br_en (cmp_taken)
   );

   // op 3 is illegal and falls through to the conditional-branch path
   always_comb begin
      is_jal   = (in_op == BR_JAL);
      is_jalr  = (in_op == BR_JALR);
      taken    = (is_jal || is_jalr) ? 1'b1 : cmp_taken;
      pc_plus4 = in_pc + 32'd4;
      target   = is_jalr ? ((in_rs1_v + in_imm) & ~32'h1) : (in_pc + in_imm);

      res            = '0;
      res.rob_idx    = in_rob_idx;
      res.pd         = in_pd;
      res.rd_we      = (is_jal || is_jalr) ? in_rd_we : 1'b0;
      res.rd_v       = (is_jal || is_jalr) ? pc_plus4 : 32'd0;
      res.taken      = taken;
      res.next_pc    = taken ? target : pc_plus4;
      res.mispredict = (taken != in_pred_taken) || (taken && (target != in_pred_target));
   end

   br_res_t    mem_q [2];
   br_res_t    mem_d [2];
   logic       wptr_q, wptr_d;
   logic       rptr_q, rptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       out_valid_q, out_valid_d;
   br_res_t    out_q, out_d;
   logic       push;
   logic       pop;

   assign in_ready = (cnt_q != 2'd2);

   // The output register holds the head as it will be after this edge,
   // zeroed when the FIFO will be empty.
   always_comb begin
      push     = in_valid && in_ready && !flush;
      pop      = (cnt_q != 2'd0) && out_ready && !flush;
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wptr_q] = res;
         wptr_d        = ~wptr_q;
      end
      if (pop) begin
         rptr_d = ~rptr_q;
      end
      if (push && !pop) begin
         cnt_d = cnt_q + 2'd1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 2'd1;
      end
      if (flush) begin
         wptr_d = 1'b0;
         rptr_d = 1'b0;
         cnt_d  = 2'd0;
      end
      out_valid_d = (cnt_d != 2'd0);
      out_d       = out_valid_d ? mem_d[rptr_d] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         cnt_q       <= 2'd0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
   end

   assign out_valid      = out_valid_q;
   assign out_rob_idx    = out_q.rob_idx;
   assign out_pd         = out_q.pd;
   assign out_rd_we      = out_q.rd_we;
   assign out_rd_v       = out_q.rd_v;
   assign out_taken      = out_q.taken;
   assign out_next_pc    = out_q.next_pc;
   assign out_mispredict = out_q.mispredict;

endmodule

// File: tb/tb_br_fu.sv
// Testbench for br_fu: directed vector table, hand-written FIFO/flush/reset
// sequences, then randomized traffic checked against a queue-based model.
module tb_br_fu;

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  cmpop;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        pt;
      logic [31:0] ptgt;
      logic [4:0]  rob;
      logic [5:0]  pd;
      logic        we;
   } op_t;

   typedef struct packed {
      logic [4:0]  rob;
      logic [5:0]  pd;
      logic        we;
      logic [31:0] rd_v;
      logic        taken;
      logic [31:0] npc;
      logic        mis;
   } res_t;

   typedef struct {
      op_t         i;
      logic        taken;
      logic [31:0] npc;
      logic        mis;
      logic        we;
      logic [31:0] rd_v;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = '0;
   logic [2:0]  in_cmpop = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_rs1_v = '0;
   logic [31:0] in_rs2_v = '0;
   logic [31:0] in_imm = '0;
   logic        in_pred_taken = 1'b0;
   logic [31:0] in_pred_target = '0;
   logic [4:0]  in_rob_idx = '0;
   logic [5:0]  in_pd = '0;
   logic        in_rd_we = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_rob_idx;
   logic [5:0]  out_pd;
   logic        out_rd_we;
   logic [31:0] out_rd_v;
   logic        out_taken;
   logic [31:0] out_next_pc;
   logic        out_mispredict;

   int checks = 0;
   int errors = 0;
   res_t exp_q[$];
   vec_t vecs[9];

   br_fu dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cmpop(in_cmpop),
      .in_pc(in_pc), .in_rs1_v(in_rs1_v), .in_rs2_v(in_rs2_v), .in_imm(in_imm),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .in_rob_idx(in_rob_idx), .in_pd(in_pd), .in_rd_we(in_rd_we),
      .out_valid(out_valid), .out_ready(out_ready), .out_rob_idx(out_rob_idx),
      .out_pd(out_pd), .out_rd_we(out_rd_we), .out_rd_v(out_rd_v),
      .out_taken(out_taken), .out_next_pc(out_next_pc), .out_mispredict(out_mispredict)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Spec-level reference: direction from funct3 semantics, then target/link rules.
   function automatic res_t ref_res(input op_t o);
      res_t r;
      logic taken;
      logic jump;
      logic [31:0] tgt;
      jump = (o.op == 2'd1) || (o.op == 2'd2);
      case (o.cmpop)
         3'b000: taken = (o.rs1 == o.rs2);
         3'b001: taken = (o.rs1 != o.rs2);
         3'b100: taken = ($signed(o.rs1) < $signed(o.rs2));
         3'b101: taken = ($signed(o.rs1) >= $signed(o.rs2));
         3'b110: taken = (o.rs1 < o.rs2);
         3'b111: taken = (o.rs1 >= o.rs2);
         default: taken = 1'b0;
      endcase
      if (jump) taken = 1'b1;
      if (o.op == 2'd2) tgt = (o.rs1 + o.imm) & 32'hFFFF_FFFE;
      else tgt = o.pc + o.imm;
      r.rob   = o.rob;
      r.pd    = o.pd;
      r.we    = jump ? o.we : 1'b0;
      r.rd_v  = jump ? o.pc + 32'd4 : 32'd0;
      r.taken = taken;
      r.npc   = taken ? tgt : o.pc + 32'd4;
      r.mis   = (taken != o.pt) || (taken && tgt != o.ptgt);
      return r;
   endfunction

   task automatic drive_op(input op_t o, input logic v);
      in_valid       = v;
      in_op          = o.op;
      in_cmpop       = o.cmpop;
      in_pc          = o.pc;
      in_rs1_v       = o.rs1;
      in_rs2_v       = o.rs2;
      in_imm         = o.imm;
      in_pred_taken  = o.pt;
      in_pred_target = o.ptgt;
      in_rob_idx     = o.rob;
      in_pd          = o.pd;
      in_rd_we       = o.we;
   endtask

   function automatic op_t mk(input logic [1:0] op, input logic [2:0] c, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                              input logic pt, input logic [31:0] ptgt, input logic [4:0] rob);
      op_t o;
      o.op = op; o.cmpop = c; o.pc = pc; o.rs1 = a; o.rs2 = b; o.imm = imm;
      o.pt = pt; o.ptgt = ptgt; o.rob = rob; o.pd = 6'(rob + 5'd3); o.we = 1'b1;
      return o;
   endfunction

   task automatic chk_head(input string nm, input res_t e);
      chk({nm, ".valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".rob"}, 32'(out_rob_idx), 32'(e.rob));
      chk({nm, ".pd"}, 32'(out_pd), 32'(e.pd));
      chk({nm, ".rd_we"}, 32'(out_rd_we), 32'(e.we));
      chk({nm, ".rd_v"}, out_rd_v, e.rd_v);
      chk({nm, ".taken"}, 32'(out_taken), 32'(e.taken));
      chk({nm, ".next_pc"}, out_next_pc, e.npc);
      chk({nm, ".mispredict"}, 32'(out_mispredict), 32'(e.mis));
   endtask

   task automatic chk_empty(input string nm);
      chk({nm, ".valid"}, 32'(out_valid), 32'd0);
      chk({nm, ".rob"}, 32'(out_rob_idx), 32'd0);
      chk({nm, ".pd"}, 32'(out_pd), 32'd0);
      chk({nm, ".rd_we"}, 32'(out_rd_we), 32'd0);
      chk({nm, ".rd_v"}, out_rd_v, 32'd0);
      chk({nm, ".taken"}, 32'(out_taken), 32'd0);
      chk({nm, ".next_pc"}, out_next_pc, 32'd0);
      chk({nm, ".mispredict"}, 32'(out_mispredict), 32'd0);
   endtask

   initial begin
      op_t o;
      op_t ops[3];
      res_t e;
      int acc;
      logic pop;

      vecs[0] = '{mk(2'd0, 3'b000, 32'h1000, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0, 5'd1),
                  1'b1, 32'h1020, 1'b1, 1'b0, 32'h0};
      vecs[1] = '{mk(2'd0, 3'b100, 32'h2000, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h2040, 5'd2),
                  1'b1, 32'h2040, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{mk(2'd0, 3'b110, 32'h2000, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h2040, 5'd3),
                  1'b0, 32'h2004, 1'b1, 1'b0, 32'h0};
      vecs[3] = '{mk(2'd2, 3'b000, 32'h80, 32'h2003, 32'd0, 32'h4, 1'b1, 32'h2006, 5'd4),
                  1'b1, 32'h2006, 1'b0, 1'b1, 32'h84};
      vecs[4] = '{mk(2'd1, 3'b000, 32'h100, 32'd0, 32'd0, 32'hFFFF_FFF0, 1'b1, 32'h200, 5'd5),
                  1'b1, 32'hF0, 1'b1, 1'b1, 32'h104};
      vecs[5] = '{mk(2'd3, 3'b001, 32'h300, 32'd1, 32'd2, 32'h8, 1'b0, 32'h0, 5'd6),
                  1'b1, 32'h308, 1'b1, 1'b0, 32'h0};
      vecs[6] = '{mk(2'd0, 3'b010, 32'h400, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 5'd7),
                  1'b0, 32'h404, 1'b0, 1'b0, 32'h0};
      vecs[7] = '{mk(2'd0, 3'b101, 32'h500, 32'h8000_0000, 32'd0, 32'h10, 1'b1, 32'h510, 5'd8),
                  1'b0, 32'h504, 1'b1, 1'b0, 32'h0};
      vecs[8] = '{mk(2'd0, 3'b111, 32'h600, 32'h8000_0000, 32'd0, 32'hC, 1'b1, 32'h60C, 5'd9),
                  1'b1, 32'h60C, 1'b0, 1'b0, 32'h0};

      // reset state
      #12;
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk_empty("reset");
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // directed vectors, one op at a time into an empty FIFO
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         drive_op(vecs[k].i, 1'b1);
         @(negedge clk);
         in_valid = 1'b0;
         e.rob = vecs[k].i.rob; e.pd = vecs[k].i.pd; e.we = vecs[k].we; e.rd_v = vecs[k].rd_v;
         e.taken = vecs[k].taken; e.npc = vecs[k].npc; e.mis = vecs[k].mis;
         chk_head($sformatf("vec%0d", k), e);
      end
      @(negedge clk);
      chk_empty("vec_drained");

      // back-to-back issue with out_ready low
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++)
         ops[k] = mk(2'd1, 3'b000, 32'h1000 + 32'(k * 16), 0, 0, 32'h40, 1'b1, 32'h0, 5'(10 + k));
      @(negedge clk);
      chk("b2b.rdy0", 32'(in_ready), 32'd1);
      drive_op(ops[0], 1'b1);
      @(negedge clk);
      chk("b2b.rdy1", 32'(in_ready), 32'd1);
      drive_op(ops[1], 1'b1);
      @(negedge clk);
      chk("b2b.rdy2", 32'(in_ready), 32'd0);
      drive_op(ops[2], 1'b1);
      repeat (2) begin
         @(negedge clk);
         chk("b2b.stall_rdy", 32'(in_ready), 32'd0);
         chk_head("b2b.hold", ref_res(ops[0]));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("b2b.after_pop_rdy", 32'(in_ready), 32'd1);
      chk_head("b2b.second", ref_res(ops[1]));
      @(negedge clk);
      in_valid = 1'b0;
      chk_head("b2b.third", ref_res(ops[2]));
      @(negedge clk);
      chk_empty("b2b.drained");

      // flush with two entries buffered and an issue on the flush cycle
      out_ready = 1'b0;
      drive_op(ops[0], 1'b1);
      @(negedge clk);
      drive_op(ops[1], 1'b1);
      @(negedge clk);
      flush = 1'b1;
      o = mk(2'd1, 3'b000, 32'h7000, 0, 0, 32'h4, 1'b1, 32'h7004, 5'd20);
      drive_op(o, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush.in_ready", 32'(in_ready), 32'd1);
      chk_empty("flush");
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("flush.never", 32'(out_valid), 32'd0);
      end

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      drive_op(ops[2], 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk_head("prerst", ref_res(ops[2]));
      #2 rst_n = 1'b0;
      #1;
      chk_empty("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      drive_op(ops[1], 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      chk_head("rst.one", ref_res(ops[1]));
      @(negedge clk);
      chk_empty("rst.only_one");

      // randomized traffic against the queue model
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         chk("rnd.in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
         if (exp_q.size() > 0) chk_head("rnd", exp_q[0]);
         else chk_empty("rnd.empty");
         o.op    = 2'($urandom_range(0, 3));
         o.cmpop = 3'($urandom_range(0, 7));
         o.pc    = $urandom & 32'hFFFF_FFFC;
         o.rs1   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
         o.rs2   = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
         o.imm   = $urandom;
         o.pt    = 1'($urandom_range(0, 1));
         o.ptgt  = ($urandom_range(0, 1) == 1) ? ref_res(o).npc : $urandom;
         o.rob   = 5'($urandom);
         o.pd    = 6'($urandom);
         o.we    = 1'($urandom_range(0, 1));
         drive_op(o, 1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 19) == 0);
         acc = int'(in_valid) & int'(exp_q.size() < 2);
         pop = (exp_q.size() > 0) && out_ready;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc != 0) exp_q.push_back(ref_res(o));
         end
         @(negedge clk);
      end

      in_valid = 1'b0;
      flush = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
